freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 30 +++
 rtl/freq_meter.sv | 123 ++++++++++++
 tb/tb_freq_meter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and default sizing for the frequency meter.
// Holds the FSM state enum and default counter/lock widths.
package freq_meter_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int LOCK_CNT_DEF = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } fm_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus one delay flop for rising-edge detect.
// Ports: clk, rst (sync, active-high), sig_in -> level (s2), rise.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a slow waveform in clk cycles.
// Ports: clk, rst, sig_in -> period, high_time, meas_valid, locked, timeout.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_CNT);

  logic level;
  logic rise;

  fm_state_e        state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [MW-1:0]    match_q, match_d;
  logic             prev_q, prev_d;
  logic             mv_q, mv_d;
  logic             to_q, to_d;

  sync_edge_det u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .level  (level),
    .rise   (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      match_q  <= '0;
      prev_q   <= 1'b0;
      mv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      match_q  <= match_d;
      prev_q   <= prev_d;
      mv_q     <= mv_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    match_d  = match_q;
    prev_d   = prev_q;
    mv_d     = 1'b0;
    to_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
          per_d   = CNT_ONE;
          hi_d    = CNT_ONE;
          prev_d  = 1'b0;
        end
      end
      MEASURE: begin
        // An edge on the terminal count wins over the timeout.
        if (rise) begin
          period_d = per_q;
          high_d   = hi_q;
          mv_d     = 1'b1;
          per_d    = CNT_ONE;
          hi_d     = CNT_ONE;
          prev_d   = 1'b1;
          // period_q still holds the previous measurement here.
          if (!prev_q || per_q != period_q)
            match_d = '0;
          else if (match_q != LOCK_V)
            match_d = match_q + 1'b1;
        end else if (per_q == CNT_MAX) begin
          state_d = IDLE;
          to_d    = 1'b1;
          match_d = '0;
          prev_d  = 1'b0;
        end else begin
          per_d = per_q + 1'b1;
          hi_d  = hi_q + CNT_W'(level);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign locked     = (match_q == LOCK_V);
  assign timeout    = to_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (CNT_W=4, LOCK_CNT=4).
// Directed waveforms then random ones against a timestamp-based model.
module tb_freq_meter;

  localparam int W    = 4;
  localparam int LOCK = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         locked;
  logic         timeout;

  freq_meter #(
    .CNT_W    (W),
    .LOCK_CNT (LOCK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model: sampled levels, then edge timestamps and level history.
  logic   m_s1 = 1'b0;
  logic   m_s2 = 1'b0;
  logic   m_s3 = 1'b0;
  bit     in_meas   = 0;
  bit     have_prev = 0;
  int     last_rise = 0;
  int     prev_p    = 0;
  int     streak    = 0;
  int     hist[$];

  logic [W-1:0] e_period = '0;
  logic [W-1:0] e_high   = '0;
  logic         e_mv     = 1'b0;
  logic         e_to     = 1'b0;
  logic         e_locked = 1'b0;

  task automatic model_step(input logic s, input logic r);
    logic rise;
    int   p;
    int   h;
    rise = m_s2 & ~m_s3;
    e_mv = 1'b0;
    e_to = 1'b0;
    if (r) begin
      e_period  = '0;
      e_high    = '0;
      in_meas   = 0;
      have_prev = 0;
      streak    = 0;
      hist.delete();
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      m_s3 = 1'b0;
    end else begin
      if (in_meas) begin
        if (rise) begin
          p = cyc - last_rise;
          h = 0;
          foreach (hist[i]) h += hist[i];
          e_period = p[W-1:0];
          e_high   = h[W-1:0];
          e_mv     = 1'b1;
          if (have_prev && p == prev_p)
            streak = (streak < LOCK) ? streak + 1 : LOCK;
          else
            streak = 0;
          have_prev = 1;
          prev_p    = p;
          last_rise = cyc;
          hist.delete();
          hist.push_back(1);
        end else if (cyc - last_rise == MAXV) begin
          e_to      = 1'b1;
          in_meas   = 0;
          have_prev = 0;
          streak    = 0;
        end else begin
          hist.push_back(int'(m_s2));
        end
      end else if (rise) begin
        in_meas   = 1;
        have_prev = 0;
        last_rise = cyc;
        hist.delete();
        hist.push_back(1);
      end
      m_s3 = m_s2;
      m_s2 = m_s1;
      m_s1 = s;
    end
    e_locked = (streak == LOCK);
  endtask

  task automatic check_outputs();
    vectors++;
    assert (period === e_period) else begin
      miscompares++;
      $error("FAIL period cyc=%0d observed %0d expected %0d",
             cyc, period, e_period);
    end
    vectors++;
    assert (high_time === e_high) else begin
      miscompares++;
      $error("FAIL high_time cyc=%0d observed %0d expected %0d",
             cyc, high_time, e_high);
    end
    vectors++;
    assert (meas_valid === e_mv) else begin
      miscompares++;
      $error("FAIL meas_valid cyc=%0d observed %b expected %b",
             cyc, meas_valid, e_mv);
    end
    vectors++;
    assert (locked === e_locked) else begin
      miscompares++;
      $error("FAIL locked cyc=%0d observed %b expected %b",
             cyc, locked, e_locked);
    end
    vectors++;
    assert (timeout === e_to) else begin
      miscompares++;
      $error("FAIL timeout cyc=%0d observed %b expected %b",
             cyc, timeout, e_to);
    end
  endtask

  task automatic tick(input logic s, input logic r);
    sig_in = s;
    rst    = r;
    model_step(s, r);
    @(posedge clk);
    #1;
    check_outputs();
    cyc++;
  endtask

  task automatic wave(input int hi, input int lo);
    for (int i = 0; i < hi; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < lo; i++) tick(1'b0, 1'b0);
  endtask

  int hi_len = 3;
  int lo_len = 2;

  initial begin
    sig_in = 1'b0;
    rst    = 1'b1;
    // Reset state
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    // 3 high / 2 low: period 5, high 3, lock on 6th edge
    for (int i = 0; i < 9; i++) wave(3, 2);
    // One period of 6 drops lock, then relock
    wave(3, 3);
    for (int i = 0; i < 7; i++) wave(3, 2);
    // Stuck low: timeout 15 cycles after load
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0);
    // Period exactly 2^W-1: measurement, no timeout
    for (int i = 0; i < 6; i++) wave(1, 14);
    // Period 2^W: timeout, then restart
    wave(1, 15);
    wave(1, 15);
    for (int i = 0; i < 4; i++) wave(2, 3);
    // Reset pulse mid-period
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) wave(3, 2);
    // Constant high from reset
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    // Random waveforms, sometimes repeated to build lock
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        hi_len = $urandom_range(1, 9);
        lo_len = $urandom_range(1, 9);
      end
      if ($urandom_range(0, 29) == 0)
        tick(1'($urandom_range(0, 1)), 1'b1);
      wave(hi_len, lo_len);
    end
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
